// File: rtl/sw_report_ctl.sv
// Switch reporter: synchronises and debounces 8 board switches, then offers each new
// stable value as a UART TX word over valid/ready. Define SW_HEADER_EN for header+data packets.
module sw_report_ctl #(
  parameter int BYTE            = 4,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [7:0]                          SW,
  input  logic                                read_ready,
  output logic                                read_valid,
  output logic [((BYTE == 1) ? 4 : 16)-1:0]   read_data
);

  localparam int DW = (BYTE == 1) ? 4 : 16;
  localparam logic [DW-1:0]    HDR_WORD = (DW == 4) ? DW'(4'hA) : DW'(16'h00A5);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HDR, SEND} state_t;

  state_t            state_q, state_d;
  logic [7:0]        s1_q, s2_q, cand_q, stable_q;
  logic [7:0]        last_q, last_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DW-1:0]     data_q, data_d;
  logic [DW-1:0]     word;

  // Synchroniser and debounce: any bit change restarts the count, which saturates at CNT_MAX.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      s1_q <= SW;
      s2_q <= s1_q;
      if (s2_q != cand_q) begin
        cand_q <= s2_q;
        cnt_q  <= '0;
      end else if (cnt_q == CNT_MAX) begin
        stable_q <= cand_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  generate
    if (DW == 4) begin : g_narrow
      assign word = stable_q[3:0];
    end else begin : g_wide
      assign word = {8'h00, stable_q};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  // Word and last_sent are captured on leaving IDLE, so later stable changes cannot alter a pending report.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (stable_q != last_q) begin
          data_d = word;
          last_d = stable_q;
`ifdef SW_HEADER_EN
          state_d = HDR;
`else
          state_d = SEND;
`endif
        end
      end
      HDR:     if (read_ready) state_d = SEND;
      SEND:    if (read_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    read_valid = (state_q == HDR) || (state_q == SEND);
    read_data  = (state_q == HDR) ? HDR_WORD : data_q;
  end

endmodule
